// File: rtl/synth_audio_pkg.sv
// Shared types and constants for the synth audio playback path.
// Exports frame geometry, the player FSM state type, the stereo frame word
// layout, and a helper that expands a stereo word into the 64-bit I2S frame.
package synth_audio_pkg;

  localparam int unsigned FRAME_BITS  = 64;
  localparam int unsigned SLOT_BITS   = 32;
  localparam int unsigned SAMPLE_BITS = 16;
  localparam int unsigned BIT_CNT_W   = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE,
    PRIME_RD,
    PRIME_WAIT,
    PLAY
  } player_state_t;

  // Left occupies the upper half of the BRAM word.
  typedef struct packed {
    logic signed [SAMPLE_BITS-1:0] left;
    logic signed [SAMPLE_BITS-1:0] right;
  } stereo_frame_t;

  // Standard I2S: each sample's MSB sits one BCLK after the LRCLK edge,
  // the remainder of each 32-bit slot is padded with zeros.
  function automatic logic [FRAME_BITS-1:0] build_frame(input stereo_frame_t w);
    return {1'b0, w.left, {SAMPLE_BITS{1'b0}}, w.right,
            {(SLOT_BITS - SAMPLE_BITS - 1){1'b0}}};
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit-clock generator.
// Divides the fabric clock down to BCLK and tracks the bit position within a
// 64-bit frame.
//   clk_i      fabric clock
//   rst_ni     asynchronous active-low reset
//   bclk_o     bit clock, half-period of CLK_DIV clk cycles
//   fall_evt_o high during the clk cycle whose closing edge drives BCLK 1->0
//   bit_cnt_o  current bit position in the frame (0..63)
module i2s_clkgen
  import synth_audio_pkg::*;
#(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic                 bclk_o,
  output logic                 fall_evt_o,
  output logic [BIT_CNT_W-1:0] bit_cnt_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0]      div_cnt_q, div_cnt_d;
  logic                 bclk_q, bclk_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 term_cnt;

  assign term_cnt   = (div_cnt_q == DivW'(CLK_DIV - 1));
  assign fall_evt_o = term_cnt && bclk_q;

  always_comb begin
    div_cnt_d = term_cnt ? '0 : div_cnt_q + 1'b1;
    bclk_d    = term_cnt ? ~bclk_q : bclk_q;
    bit_cnt_d = fall_evt_o ? bit_cnt_q + 1'b1 : bit_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bclk_o    = bclk_q;
  assign bit_cnt_o = bit_cnt_q;

endmodule

// File: rtl/synth_bram_i2s_player.sv
// Plays stereo frames from a BRAM ring out over I2S.
// One 32-bit word ({left, right}) per frame is fetched from BRAM port A and
// serialised as a 64-BCLK I2S frame; BCLK/LRCLK run continuously.
//   clk, rstn           fabric clock, asynchronous active-low reset
//   enable              playback request
//   BRAM_*              read-only BRAM port A (1-clk read latency)
//   audio_I2S_*         bit clock, LRCLK (0 = left) and serial data
//   rd_idx              ring index of the next word to fetch
//   frame_strobe        one-clk pulse after every frame boundary
module synth_bram_i2s_player
  import synth_audio_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 8,
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enable,
  output logic [31:0]              BRAM_addr,
  output logic                     BRAM_clk,
  output logic [31:0]              BRAM_din,
  input  logic [31:0]              BRAM_dout,
  output logic                     BRAM_en,
  output logic                     BRAM_rst,
  output logic [3:0]               BRAM_we,
  output logic                     audio_I2S_bclk,
  output logic                     audio_I2S_pblrc,
  output logic                     audio_I2S_pbdat,
  output logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     frame_strobe
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  logic                  fall_evt;
  logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic                  boundary, fetch_evt;
  logic [FRAME_BITS-1:0] frame_vec;

  player_state_t         state_q, state_d;
  logic                  en_q, en_d;
  logic                  cap_q, cap_d;
  stereo_frame_t         next_word_q, next_word_d;
  logic                  next_valid_q, next_valid_d;
  logic [IdxW-1:0]       rd_idx_q, rd_idx_d;
  logic                  stop_q, stop_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic                  pbdat_q, pbdat_d;
  logic                  pblrc_q, pblrc_d;
  logic                  strobe_q, strobe_d;

  i2s_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk_i     (clk),
    .rst_ni    (rstn),
    .bclk_o    (audio_I2S_bclk),
    .fall_evt_o(fall_evt),
    .bit_cnt_o (bit_cnt)
  );

  assign bit_cnt_nxt = bit_cnt + 1'b1;
  assign boundary    = fall_evt && (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
  // Fetch on entry to the right slot, but never over an unplayed prefetch
  // (happens when priming completes early in an idle frame).
  assign fetch_evt   = (state_q == PLAY) && !stop_q && !next_valid_q && fall_evt &&
                       (bit_cnt == BIT_CNT_W'(SLOT_BITS - 1));
  assign frame_vec   = next_valid_q ? build_frame(next_word_q) : '0;

  always_comb begin
    state_d      = state_q;
    en_d         = 1'b0;
    cap_d        = en_q;
    next_word_d  = next_word_q;
    next_valid_d = next_valid_q;
    rd_idx_d     = rd_idx_q;
    stop_d       = stop_q;
    sr_d         = sr_q;
    pbdat_d      = pbdat_q;
    pblrc_d      = pblrc_q;
    strobe_d     = boundary;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = PRIME_RD;
          en_d    = 1'b1;
        end
      end
      PRIME_RD:   state_d = PRIME_WAIT;
      PRIME_WAIT: state_d = PLAY;
      PLAY: begin
        if (fetch_evt) en_d = 1'b1;
        // enable is only looked at on frame boundaries; a drop lets the
        // already-prefetched word play out one more frame before going idle.
        if (boundary) begin
          if (stop_q) begin
            state_d = IDLE;
            stop_d  = 1'b0;
          end else if (!enable) begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fall_evt) begin
      pblrc_d = (bit_cnt_nxt >= BIT_CNT_W'(SLOT_BITS));
      if (boundary) begin
        pbdat_d      = frame_vec[FRAME_BITS-1];
        sr_d         = {frame_vec[FRAME_BITS-2:0], 1'b0};
        next_valid_d = 1'b0;
      end else begin
        pbdat_d = sr_q[FRAME_BITS-1];
        sr_d    = {sr_q[FRAME_BITS-2:0], 1'b0};
      end
    end

    // Capture wins over the boundary clear so a word landing on the boundary
    // cycle still plays in the following frame.
    if (cap_q) begin
      next_word_d  = stereo_frame_t'(BRAM_dout);
      next_valid_d = 1'b1;
      rd_idx_d     = (rd_idx_q == IdxW'(DEPTH - 1)) ? '0 : rd_idx_q + 1'b1;
    end

    if ((state_q == PLAY) && boundary && stop_q) begin
      rd_idx_d     = '0;
      next_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      en_q         <= 1'b0;
      cap_q        <= 1'b0;
      next_word_q  <= '0;
      next_valid_q <= 1'b0;
      rd_idx_q     <= '0;
      stop_q       <= 1'b0;
      sr_q         <= '0;
      pbdat_q      <= 1'b0;
      pblrc_q      <= 1'b0;
      strobe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      cap_q        <= cap_d;
      next_word_q  <= next_word_d;
      next_valid_q <= next_valid_d;
      rd_idx_q     <= rd_idx_d;
      stop_q       <= stop_d;
      sr_q         <= sr_d;
      pbdat_q      <= pbdat_d;
      pblrc_q      <= pblrc_d;
      strobe_q     <= strobe_d;
    end
  end

  assign BRAM_addr       = BASE_ADDR + (32'(rd_idx_q) << 2);
  assign BRAM_clk        = clk;
  assign BRAM_din        = '0;
  assign BRAM_en         = en_q;
  assign BRAM_rst        = 1'b0;
  assign BRAM_we         = '0;
  assign audio_I2S_pblrc = pblrc_q;
  assign audio_I2S_pbdat = pbdat_q;
  assign rd_idx          = rd_idx_q;
  assign frame_strobe    = strobe_q;

endmodule

// File: tb/tb_synth_bram_i2s_player.sv
module tb_synth_bram_i2s_player;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] BRAM_addr;
  logic        BRAM_clk;
  logic [31:0] BRAM_din;
  logic [31:0] BRAM_dout = '0;
  logic        BRAM_en;
  logic        BRAM_rst;
  logic [3:0]  BRAM_we;
  logic        bclk, pblrc, pbdat;
  logic [1:0]  rd_idx;
  logic        frame_strobe;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [4];
  logic [31:0] exp_frames [$];
  logic [31:0] exp_addr [$];

  always #5 clk = ~clk;

  synth_bram_i2s_player #(
    .CLK_DIV  (4),
    .DEPTH    (4),
    .BASE_ADDR(32'h0)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .enable         (enable),
    .BRAM_addr      (BRAM_addr),
    .BRAM_clk       (BRAM_clk),
    .BRAM_din       (BRAM_din),
    .BRAM_dout      (BRAM_dout),
    .BRAM_en        (BRAM_en),
    .BRAM_rst       (BRAM_rst),
    .BRAM_we        (BRAM_we),
    .audio_I2S_bclk (bclk),
    .audio_I2S_pblrc(pblrc),
    .audio_I2S_pbdat(pbdat),
    .rd_idx         (rd_idx),
    .frame_strobe   (frame_strobe)
  );

  // 1-clk latency BRAM read port
  always @(posedge clk) if (BRAM_en) BRAM_dout <= mem[BRAM_addr[3:2]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Monitor: timing, BRAM reads against the address queue, I2S receiver
  // against the frame queue.
  initial begin
    int          strobe_cyc, bclk_cyc, lr_cyc, rx_idx;
    logic        bclk_first, lr_first, bclk_prev, lr_prev, rx_on, rx_lr_prev;
    logic [63:0] rx_dat, rx_lr, rest;
    logic [15:0] l, r;
    logic [31:0] e;
    strobe_cyc = 0; bclk_cyc = 0; lr_cyc = 0; rx_idx = 0;
    bclk_first = 1'b1; lr_first = 1'b1; bclk_prev = 1'b0; lr_prev = 1'b0;
    rx_on = 1'b0; rx_lr_prev = 1'b0; rx_dat = '0; rx_lr = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        strobe_cyc = 0; bclk_cyc = 0; lr_cyc = 0;
        bclk_first = 1'b1; lr_first = 1'b1; bclk_prev = 1'b0; lr_prev = 1'b0;
        rx_on = 1'b0; rx_lr_prev = 1'b0;
      end else begin
        chk("bram_static", 64'({BRAM_we, BRAM_din, BRAM_rst, BRAM_clk}), 64'd0);
        if (BRAM_en) begin
          if (exp_addr.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL bram_read: read at addr %0h, expected no read", BRAM_addr);
          end else begin
            chk("bram_addr", 64'(BRAM_addr), 64'(exp_addr.pop_front()));
          end
        end
        strobe_cyc++;
        if (frame_strobe) begin
          chk("strobe_period", 64'(strobe_cyc), 64'd512);
          strobe_cyc = 0;
        end
        lr_cyc++;
        if (pblrc && !lr_prev) begin
          chk("lrclk_period", 64'(lr_cyc), lr_first ? 64'd256 : 64'd512);
          lr_first = 1'b0;
          lr_cyc   = 0;
        end
        bclk_cyc++;
        if (bclk && !bclk_prev) begin
          chk("bclk_period", 64'(bclk_cyc), bclk_first ? 64'd4 : 64'd8);
          bclk_first = 1'b0;
          bclk_cyc   = 0;
          if (!rx_on && rx_lr_prev && !pblrc) begin
            rx_on  = 1'b1;
            rx_idx = 0;
          end
          if (rx_on) begin
            rx_dat[rx_idx] = pbdat;
            rx_lr[rx_idx]  = pblrc;
            if (rx_idx == 63) begin
              rest = rx_dat;
              for (int i = 0; i < 16; i++) begin
                l[15-i] = rx_dat[1+i];
                r[15-i] = rx_dat[33+i];
                rest[1+i]  = 1'b0;
                rest[33+i] = 1'b0;
              end
              if (exp_frames.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL frame: got %h/%h, expected no frame", l, r);
              end else begin
                e = exp_frames.pop_front();
                chk("frame_left", 64'(l), 64'(e[31:16]));
                chk("frame_right", 64'(r), 64'(e[15:0]));
                chk("frame_pad", rest, 64'd0);
                chk("frame_lrclk", rx_lr, 64'hFFFF_FFFF_0000_0000);
              end
              rx_idx = 0;
            end else begin
              rx_idx++;
            end
          end
          rx_lr_prev = pblrc;
        end
        bclk_prev = bclk;
        lr_prev   = pblrc;
      end
    end
  end

  task automatic wait_strobe();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_strobe && n < 700);
    if (!frame_strobe) begin
      n_checks++; n_errors++;
      $display("FAIL strobe_timeout: no frame_strobe in %0d cycles, expected one", n);
    end
  endtask

  initial begin
    mem[0] = 32'hA5C3_8001;
    mem[1] = 32'h0002_0002;
    mem[2] = 32'h0;
    mem[3] = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({bclk, pblrc, pbdat, BRAM_en, frame_strobe, rd_idx}), 64'd0);
    chk("reset_addr", 64'(BRAM_addr), 64'd0);
    #2 rstn = 1'b1;

    // Idle: two zero frames, no reads
    exp_frames.push_back(32'h0);
    exp_frames.push_back(32'h0);
    wait_strobe();
    wait_strobe();

    // Single word then early stop: frame 3 = word 0, frame 4 = prefetched word 1
    enable = 1'b1;
    exp_addr.push_back(32'd0);
    exp_addr.push_back(32'd4);
    exp_frames.push_back(32'hA5C3_8001);
    exp_frames.push_back(32'h0002_0002);
    exp_frames.push_back(32'h0);
    wait_strobe();
    repeat (80) @(negedge clk);
    enable = 1'b0;
    wait_strobe();
    wait_strobe();
    chk("rd_idx_after_stop", 64'(rd_idx), 64'd0);

    // Continuous play with ring wrap, then stop while word 1 plays
    mem[0] = 32'h0001_0001;
    mem[1] = 32'h0002_0002;
    mem[2] = 32'h0003_0003;
    mem[3] = 32'h0004_0004;
    enable = 1'b1;
    foreach (mem[i]) exp_addr.push_back(32'(i) * 4);
    exp_addr.push_back(32'd0);
    exp_addr.push_back(32'd4);
    exp_addr.push_back(32'd8);
    exp_frames.push_back(32'h0001_0001);
    exp_frames.push_back(32'h0002_0002);
    exp_frames.push_back(32'h0003_0003);
    exp_frames.push_back(32'h0004_0004);
    exp_frames.push_back(32'h0001_0001);
    exp_frames.push_back(32'h0002_0002);
    exp_frames.push_back(32'h0003_0003);
    exp_frames.push_back(32'h0);
    wait_strobe();
    wait_strobe();
    wait_strobe();
    chk("rd_idx_before_wrap", 64'(rd_idx), 64'd3);
    wait_strobe();
    chk("rd_idx_wrapped", 64'(rd_idx), 64'd0);
    wait_strobe();
    wait_strobe();
    repeat (80) @(negedge clk);
    enable = 1'b0;
    wait_strobe();
    wait_strobe();
    chk("rd_idx_idle", 64'(rd_idx), 64'd0);

    // Asynchronous reset during PLAY at bit 40
    enable = 1'b1;
    exp_addr.push_back(32'd0);
    exp_addr.push_back(32'd4);
    wait_strobe();
    repeat (320) @(negedge clk);
    chk("pre_reset_state", 64'({pblrc, rd_idx}), 64'({1'b1, 2'd2}));
    #2 rstn = 1'b0;
    enable = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({bclk, pblrc, pbdat, BRAM_en, frame_strobe, rd_idx}), 64'd0);
    chk("async_reset_addr", 64'(BRAM_addr), 64'd0);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    exp_frames.push_back(32'h0);
    wait_strobe();
    wait_strobe();
    repeat (4) @(negedge clk);

    chk("frames_pending", 64'(exp_frames.size()), 64'd0);
    chk("reads_pending", 64'(exp_addr.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
